// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Multi-cycle restoring divider sequencer for DIV/DIVU/REM/REMU,
//               one quotient bit per cycle, with RISC-V special-case results.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            div_flush,
    output logic            div_busy,
    output logic            div_valid,
    output logic [XLEN-1:0] result_divide
);

    localparam int c_CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_count;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_dvs;
    logic                r_is_rem;
    logic                r_neg1;
    logic                r_neg2;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_signed;
    logic                w_neg1;
    logic                w_neg2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_div0;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [XLEN-1:0]     w_rem_nx;
    logic [XLEN-1:0]     w_quo_nx;
    logic                w_last;
    logic [XLEN-1:0]     w_final;

    // Start decode: magnitudes only for the signed ops (opcode bit 0 clear).
    assign w_accept  = (r_state == S_IDLE) && div_start && !div_flush;
    assign w_signed  = ~div_opcode[0];
    assign w_neg1    = w_signed & operand1[XLEN-1];
    assign w_neg2    = w_signed & operand2[XLEN-1];
    assign w_mag1    = w_neg1 ? -operand1 : operand1;
    assign w_mag2    = w_neg2 ? -operand2 : operand2;
    assign w_div0    = (operand2 == '0);
    assign w_ovf     = w_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                                && (operand2 == {XLEN{1'b1}});
    assign w_special = w_div0 || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = div_opcode[1] ? operand1 : {XLEN{1'b1}};
        else if (w_ovf)
            w_special_res = div_opcode[1] ? '0 : operand1;
    end

    // One restoring step: the shifted partial remainder needs one extra bit.
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_rem_nx = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    assign w_last   = (r_count == c_CNT_W'(XLEN-1));

    always_comb begin
        if (r_is_rem)
            w_final = r_neg1 ? -w_rem_nx : w_rem_nx;
        else
            w_final = (r_neg1 ^ r_neg2) ? -w_quo_nx : w_quo_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (div_flush)
                    w_next = S_IDLE;
                else if (w_last)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= div_opcode[1];
                        r_neg1   <= w_neg1;
                        r_neg2   <= w_neg2;
                        r_dvs    <= w_mag2;
                        r_quo    <= w_mag1;
                        r_rem    <= '0;
                        r_count  <= '0;
                        if (w_special)
                            r_result <= w_special_res;
                    end
                end
                S_CALC: begin
                    // A squash leaves the previous result visible.
                    if (!div_flush) begin
                        r_rem   <= w_rem_nx;
                        r_quo   <= w_quo_nx;
                        r_count <= r_count + c_CNT_W'(1);
                        if (w_last)
                            r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_busy      = (r_state != S_IDLE);
    assign div_valid     = (r_state == S_DONE);
    assign result_divide = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Self-checking bench for div_seq_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam int c_XLEN = 32;
    localparam logic [31:0] c_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        div_start = 1'b0;
    logic [1:0]  div_opcode = 2'b00;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        div_flush = 1'b0;
    logic        div_busy;
    logic        div_valid;
    logic [31:0] result_divide;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;

    div_seq_ctrl #(.XLEN(c_XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .div_start     (div_start),
        .div_opcode    (div_opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .div_flush     (div_flush),
        .div_busy      (div_busy),
        .div_valid     (div_valid),
        .result_divide (result_divide)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == c_MIN && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics expressed with native arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == c_MIN && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : c_MIN;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it cycle by cycle; optional stray start in cycle pk.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int pk);
        logic [31:0] exp;
        int lat;
        exp = model(op, a, b);
        lat = is_special(op, a, b) ? 1 : c_XLEN + 1;
        @(negedge clk);
        div_start = 1'b1; div_opcode = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        div_start = 1'b0; operand1 = $urandom; operand2 = $urandom; div_opcode = 2'($urandom);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
                div_start = 1'b0;
            end
            chk({tag, " busy"}, 32'(div_busy), 32'd1);
            if (c < lat) begin
                chk({tag, " early valid"}, 32'(div_valid), 32'd0);
                chk({tag, " result hold"}, result_divide, last_exp);
            end else begin
                chk({tag, " valid"}, 32'(div_valid), 32'd1);
                chk({tag, " result"}, result_divide, exp);
            end
            if (c == pk) begin
                @(negedge clk);
                div_start = 1'b1; operand1 = $urandom; operand2 = $urandom;
                div_opcode = 2'($urandom);
            end
        end
        last_exp = exp;
        @(posedge clk); #1;
        div_start = 1'b0;
        chk({tag, " idle busy"}, 32'(div_busy), 32'd0);
        chk({tag, " idle valid"}, 32'(div_valid), 32'd0);
        chk({tag, " idle result"}, result_divide, last_exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset busy", 32'(div_busy), 32'd0);
        chk("reset valid", 32'(div_valid), 32'd0);
        chk("reset result", result_divide, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_op("div 100/7",   2'b00, 32'd100, 32'd7, 0);
        do_op("rem -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("div -7/2",    2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("divu max/1",  2'b01, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("remu max/16", 2'b11, 32'hFFFF_FFFF, 32'h10, 0);
        do_op("div 5/0",     2'b00, 32'd5, 32'd0, 0);
        do_op("remu 5/0",    2'b11, 32'd5, 32'd0, 0);
        do_op("div ovf",     2'b00, c_MIN, 32'hFFFF_FFFF, 0);
        do_op("rem ovf",     2'b10, c_MIN, 32'hFFFF_FFFF, 0);

        // Flush in cycle 10 of DIVU 1000/3.
        @(negedge clk);
        div_start = 1'b1; div_opcode = 2'b01; operand1 = 32'd1000; operand2 = 32'd3;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush pre busy", 32'(div_busy), 32'd1);
        @(negedge clk) div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        chk("flush busy", 32'(div_busy), 32'd0);
        chk("flush result", result_divide, last_exp);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            chk("flush no valid", 32'(div_valid), 32'd0);
        end
        chk("flush result kept", result_divide, last_exp);

        // Flush coincident with start in IDLE: not accepted.
        @(negedge clk);
        div_start = 1'b1; div_flush = 1'b1; div_opcode = 2'b00; operand1 = 32'd9; operand2 = 32'd0;
        @(posedge clk); #1;
        div_start = 1'b0; div_flush = 1'b0;
        chk("flush+start busy", 32'(div_busy), 32'd0);
        @(posedge clk); #1;
        chk("flush+start valid", 32'(div_valid), 32'd0);

        do_op("divu 1000/3", 2'b01, 32'd1000, 32'd3, 0);
        do_op("div 50/5 poke", 2'b00, 32'd50, 32'd5, 5);
        do_op("back2back poke", 2'b10, 32'd77, 32'd10, 33);

        // Reset in cycle 20 of an op.
        @(negedge clk);
        div_start = 1'b1; div_opcode = 2'b00; operand1 = 32'd12345; operand2 = 32'd7;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(div_busy), 32'd0);
        chk("rst valid", 32'(div_valid), 32'd0);
        chk("rst result", result_divide, 32'd0);
        last_exp = '0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            chk("rst no valid", 32'(div_valid), 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int pk;
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = c_MIN; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                3: b = $urandom_range(1, 15) | (b & 32'h8000_0000);
                default: ;
            endcase
            pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0;
            do_op("random", op, a, b, pk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
